// File: rtl/a2d_seq_avg.sv
// Round-robin A2D sequencer: drives the SPI monarch through the enabled slots,
// box-averages 2^AVG_LOG2 samples per slot and publishes 12-bit results.
module a2d_seq_avg #(
  parameter int unsigned NUM_CH     = 4,
  parameter logic [23:0] CH_MAP     = 24'h0008C8,  // 3-bit fields: slots 0..3 -> channels 0,1,3,4
  parameter int unsigned INTERVAL_W = 14,
  parameter int unsigned AVG_LOG2   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic                  trig_mode,
  input  logic                  trig,
  output logic [15:0]           spi_cmd,
  output logic                  spi_snd,
  input  logic                  spi_done,
  input  logic [15:0]           spi_resp,
  output logic [12*NUM_CH-1:0]  result,
  output logic [NUM_CH-1:0]     result_vld,
  output logic                  busy
);
  localparam int unsigned SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ACC_W  = 12 + AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE, CONV, CONV_WAIT, GAP1, READ, READ_WAIT, STORE, NEXT
  } state_t;

  state_t                state_q, state_d;
  logic [INTERVAL_W-1:0] timer_q, timer_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [NUM_CH-1:0]     en_q, en_d;
  logic [ACC_W-1:0]      acc_q [NUM_CH];
  logic [ACC_W-1:0]      acc_d [NUM_CH];
  logic [CNT_W-1:0]      cnt_q [NUM_CH];
  logic [CNT_W-1:0]      cnt_d [NUM_CH];
  logic [12*NUM_CH-1:0]  result_q, result_d;
  logic [NUM_CH-1:0]     result_vld_q, result_vld_d;
  logic [15:0]           spi_cmd_q, spi_cmd_d;
  logic                  spi_snd_q, spi_snd_d;
  logic                  busy_q, busy_d;

  logic [SLOT_W-1:0]     first_slot, next_slot;
  logic                  first_ok, next_ok, start;
  logic [ACC_W-1:0]      sum;
  logic                  resp_hi_unused;

  // Descending scan so the lowest qualifying slot wins.
  always_comb begin
    first_ok   = 1'b0;
    first_slot = '0;
    next_ok    = 1'b0;
    next_slot  = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (ch_en[i-1]) begin
        first_ok   = 1'b1;
        first_slot = SLOT_W'(i - 1);
      end
      if (en_q[i-1] && ((i - 1) > 32'(slot_q))) begin
        next_ok   = 1'b1;
        next_slot = SLOT_W'(i - 1);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    slot_d         = slot_q;
    en_d           = en_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_vld_d   = '0;
    start          = 1'b0;
    resp_hi_unused = ^spi_resp[15:12];
    sum            = acc_q[slot_q] + ACC_W'(spi_resp[11:0]);

    case (state_q)
      IDLE: begin
        if (trig_mode) begin
          timer_d = '0;
          start   = trig;
        end else begin
          timer_d = timer_q + 1'b1;
          start   = (timer_q == '1);
        end
        if (start) begin
          en_d = ch_en;
          if (first_ok) begin
            slot_d  = first_slot;
            state_d = CONV;
          end
        end
      end
      CONV:      state_d = CONV_WAIT;
      CONV_WAIT: if (spi_done) state_d = GAP1;
      GAP1:      state_d = READ;
      READ:      state_d = READ_WAIT;
      READ_WAIT: if (spi_done) state_d = STORE;
      STORE: begin
        if (cnt_q[slot_q] == CNT_LAST) begin
          result_d[12*slot_q +: 12] = 12'(sum >> AVG_LOG2);
          result_vld_d[slot_q]      = 1'b1;
          acc_d[slot_q]             = '0;
          cnt_d[slot_q]             = '0;
        end else begin
          acc_d[slot_q] = sum;
          cnt_d[slot_q] = cnt_q[slot_q] + 1'b1;
        end
        state_d = NEXT;
      end
      NEXT: begin
        if (next_ok) begin
          slot_d  = next_slot;
          state_d = CONV;
        end else begin
          timer_d = '0;
          state_d = IDLE;
        end
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    spi_snd_d = (state_d == CONV) || (state_d == READ);
    spi_cmd_d = '0;
    if ((state_d == CONV) || (state_d == CONV_WAIT) || (state_d == GAP1))
      spi_cmd_d = {2'b00, CH_MAP[3*slot_d +: 3], 11'b0};
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      slot_q       <= '0;
      en_q         <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      result_q     <= '0;
      result_vld_q <= '0;
      spi_cmd_q    <= '0;
      spi_snd_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      slot_q       <= slot_d;
      en_q         <= en_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
      spi_cmd_q    <= spi_cmd_d;
      spi_snd_q    <= spi_snd_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    spi_cmd    = spi_cmd_q;
    spi_snd    = spi_snd_q;
    result     = result_q;
    result_vld = result_vld_q;
    busy       = busy_q;
  end
endmodule

// File: tb/tb_a2d_seq_avg.sv
// Bench for a2d_seq_avg: SPI responder with random latency and samples,
// per-slot averaging reference model and scoreboard of published results.
module tb_a2d_seq_avg;
  localparam int NCH = 4;
  localparam int IW  = 6;
  localparam int AVG = 2;
  localparam int IDLE_CYC = 1 << IW;
  localparam int NAVG = 1 << AVG;

  typedef struct packed {
    logic [1:0]  slot;
    logic [11:0] val;
  } pub_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   ch_en;
  logic             trig_mode, trig;
  logic [15:0]      spi_cmd, spi_resp;
  logic             spi_snd, spi_done;
  logic [12*NCH-1:0] result;
  logic [NCH-1:0]   result_vld;
  logic             busy;

  always #5 clk = ~clk;

  a2d_seq_avg #(.NUM_CH(NCH), .INTERVAL_W(IW), .AVG_LOG2(AVG)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .trig_mode(trig_mode), .trig(trig),
    .spi_cmd(spi_cmd), .spi_snd(spi_snd), .spi_done(spi_done), .spi_resp(spi_resp),
    .result(result), .result_vld(result_vld), .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  int chan_tbl [NCH] = '{0, 1, 3, 4};

  logic [15:0] cmd_log [$];
  logic [15:0] samp_log [$];
  pub_t        pub_log [$];
  int          overlap = 0;
  int          busy_cycles = 0;
  int          dly_fixed = 0;
  bit          force_on = 1'b0;
  int          force_start = 0;
  logic [11:0] force_v [4] = '{12'd100, 12'd101, 12'd102, 12'd105};

  int          cmd_rd = 0, samp_rd = 0, pub_rd = 0;
  int          m_sum [NCH];
  int          m_n   [NCH];
  logic [11:0] m_res [NCH];

  // SPI monarch stand-in: each transaction completes after 1..6 (or a fixed) cycles.
  initial begin : spi_model
    int          pend;
    int          idx;
    bit          rd_phase;
    logic [15:0] presp;
    pend = 0;
    rd_phase = 1'b0;
    spi_done = 1'b0;
    spi_resp = '0;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (rst) begin
        pend = 0;
        rd_phase = 1'b0;
      end else if (pend > 0) begin
        if (spi_snd) overlap++;
        pend--;
        if (pend == 0) begin
          spi_done = 1'b1;
          spi_resp = presp;
        end
      end else if (spi_snd) begin
        cmd_log.push_back(spi_cmd);
        presp = 16'($urandom());
        if (rd_phase) begin
          idx = samp_log.size() - force_start;
          if (force_on && idx >= 0 && idx < 4) presp = {presp[15:12], force_v[idx]};
          samp_log.push_back(presp);
        end
        rd_phase = !rd_phase;
        pend = (dly_fixed > 0) ? dly_fixed : int'($urandom_range(6, 1));
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      for (int s = 0; s < NCH; s++)
        if (result_vld[s]) pub_log.push_back('{slot: 2'(s), val: result[12*s +: 12]});
      if (busy) busy_cycles++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NCH; s++) begin
      m_sum[s] = 0;
      m_n[s]   = 0;
      m_res[s] = '0;
    end
  endtask

  task automatic count_to_snd(output int t);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!spi_snd && t < 4 * IDLE_CYC);
  endtask

  task automatic wait_round(input string tag);
    int t = 0;
    while (!busy && t < 4 * IDLE_CYC) begin @(negedge clk); t++; end
    chk($sformatf("%s busy_rise", tag), busy, 1'b1);
    t = 0;
    while (busy && t < 5000) begin @(negedge clk); t++; end
    chk($sformatf("%s busy_fall", tag), busy, 1'b0);
  endtask

  task automatic trig_pulse();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  // Expected commands and published averages for one round over `mask`.
  task automatic check_round(input logic [NCH-1:0] mask, input string tag);
    logic [15:0] exp_cmd [$];
    pub_t        exp_pub [$];
    logic [15:0] smp;
    int          k;
    logic [12*NCH-1:0] exp_res;
    for (int s = 0; s < NCH; s++)
      if (mask[s]) begin
        exp_cmd.push_back({2'b00, 3'(chan_tbl[s]), 11'b0});
        exp_cmd.push_back(16'h0000);
      end
    chk($sformatf("%s ncmd", tag), cmd_log.size() - cmd_rd, exp_cmd.size());
    for (int i = 0; i < exp_cmd.size(); i++)
      if (cmd_rd + i < cmd_log.size())
        chk($sformatf("%s cmd%0d", tag, i), cmd_log[cmd_rd+i], exp_cmd[i]);
    cmd_rd = cmd_log.size();
    k = samp_rd;
    for (int s = 0; s < NCH; s++)
      if (mask[s] && k < samp_log.size()) begin
        smp = samp_log[k];
        k++;
        m_sum[s] += int'(smp[11:0]);
        m_n[s]++;
        if (m_n[s] == NAVG) begin
          m_res[s] = 12'(m_sum[s] / NAVG);
          exp_pub.push_back('{slot: 2'(s), val: m_res[s]});
          m_sum[s] = 0;
          m_n[s]   = 0;
        end
      end
    samp_rd = samp_log.size();
    chk($sformatf("%s npub", tag), pub_log.size() - pub_rd, exp_pub.size());
    for (int i = 0; i < exp_pub.size(); i++)
      if (pub_rd + i < pub_log.size())
        chk($sformatf("%s pub%0d", tag, i), pub_log[pub_rd+i], exp_pub[i]);
    pub_rd = pub_log.size();
    for (int s = 0; s < NCH; s++) exp_res[12*s +: 12] = m_res[s];
    chk($sformatf("%s result", tag), result, exp_res);
    chk($sformatf("%s overlap", tag), overlap, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk($sformatf("%s spi_snd", tag), spi_snd, 1'b0);
    chk($sformatf("%s spi_cmd", tag), spi_cmd, 16'h0);
    chk($sformatf("%s result", tag), result, '0);
    chk($sformatf("%s result_vld", tag), result_vld, '0);
    chk($sformatf("%s busy", tag), busy, 1'b0);
  endtask

  initial begin : stim
    int t;
    int c0, b0, p0;
    rst = 1'b1;
    ch_en = 4'hF;
    trig_mode = 1'b0;
    trig = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");

    // Auto mode: first round after a full interval, then four rounds to fill the averages.
    rst = 1'b0;
    count_to_snd(t);
    chk("auto first_start", t, IDLE_CYC);
    chk("auto first_cmd", spi_cmd, 16'h0000);
    chk("auto busy_at_start", busy, 1'b1);
    wait_round("auto r1");
    check_round(4'hF, "auto r1");
    for (int r = 2; r <= 4; r++) begin
      count_to_snd(t);
      chk($sformatf("auto r%0d gap", r), t, IDLE_CYC);
      wait_round($sformatf("auto r%0d", r));
      check_round(4'hF, $sformatf("auto r%0d", r));
    end

    ch_en = 4'b1010;
    count_to_snd(t);
    chk("auto 1010 gap", t, IDLE_CYC);
    wait_round("auto 1010");
    check_round(4'b1010, "auto 1010");

    ch_en = 4'b0000;
    c0 = cmd_log.size();
    b0 = busy_cycles;
    repeat (3 * IDLE_CYC + 10) @(negedge clk);
    chk("en0 no_snd", cmd_log.size() - c0, 0);
    chk("en0 no_busy", busy_cycles - b0, 0);

    // Software trigger mode: timer held, trig starts exactly one round.
    trig_mode = 1'b1;
    ch_en = 4'hF;
    c0 = cmd_log.size();
    repeat (2 * IDLE_CYC) @(negedge clk);
    chk("trig idle no_snd", cmd_log.size() - c0, 0);
    dly_fixed = 37;
    trig_pulse();
    chk("trig start snd", spi_snd, 1'b1);
    chk("trig start busy", busy, 1'b1);
    @(negedge clk);
    chk("trig snd one_cycle", spi_snd, 1'b0);
    repeat (20) @(negedge clk);
    trig = 1'b1;
    trig_mode = 1'b0;
    ch_en = 4'b0001;
    @(negedge clk);
    trig = 1'b0;
    repeat (10) @(negedge clk);
    trig_mode = 1'b1;
    wait_round("trig busy");
    check_round(4'hF, "trig busy");
    c0 = cmd_log.size();
    repeat (150) @(negedge clk);
    chk("trig no_queued_round", cmd_log.size() - c0, 0);

    dly_fixed = 1;
    ch_en = 4'hF;
    trig_pulse();
    wait_round("dly1");
    check_round(4'hF, "dly1");

    // Reset while waiting on the read transaction.
    dly_fixed = 37;
    ch_en = 4'b0001;
    trig_pulse();
    t = 0;
    while ((cmd_log.size() - cmd_rd) < 2 && t < 500) begin @(negedge clk); t++; end
    chk("rst reached_read", cmd_log.size() - cmd_rd, 2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs("rst mid");
    model_reset();
    cmd_rd  = cmd_log.size();
    samp_rd = samp_log.size();
    pub_rd  = pub_log.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst no_pub", pub_log.size() - pub_rd, 0);

    // Averaging of 100,101,102,105 on slot 0 over four triggered rounds.
    dly_fixed = 0;
    force_start = samp_log.size();
    force_on = 1'b1;
    p0 = pub_log.size();
    for (int r = 1; r <= 4; r++) begin
      trig_pulse();
      wait_round($sformatf("avg r%0d", r));
      if (r == 3) chk("avg no_pub_before_4", pub_log.size() - p0, 0);
      check_round(4'b0001, $sformatf("avg r%0d", r));
    end
    chk("avg pub_count", pub_log.size() - p0, 1);
    chk("avg result0", result[11:0], 12'd102);
    chk("avg others_zero", result[47:12], '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
